frame_serializer_3bit: RTL and testbench

- Upstream feeder for the 3-bit serial palindrome detector.
- Accepts parallel frames over a valid/ready handshake and buffers them in a small FIFO.
- Emits them as a continuous, frame-aligned, MSB-first bit stream, one bit per clk.
- When no frame is queued, inserts a non-palindromic idle frame so the downstream detector's 3-bit grouping never slips.

---
 rtl/frame_serializer_3bit.sv | 117 +++++++++++
 tb/tb_frame_serializer_3bit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_serializer_3bit.sv
// -----------------------------------------------------------------------------
// frame_serializer_3bit
//
// Upstream feeder for the 3-bit serial palindrome detector. Parallel frames
// arrive over a valid/ready handshake and are queued in a small FIFO. They
// leave as a continuous, frame-aligned, MSB-first bit stream with one bit per
// clk. When the FIFO is empty at a frame boundary, a non-palindromic idle
// frame is sent instead. This keeps the detector's 3-bit grouping from
// slipping.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset (shared with the detector)
//   in_data      parallel frame; in_data[FRAME_W-1] is sent first
//   in_valid     in_data is valid this cycle
//   in_ready     FIFO can accept a frame this cycle
//   serial_out   serial bit to the detector's serial_in
//   frame_start  high while serial_out carries the MSB of a frame
//   idle_out     high for every bit of an idle-fill frame
//   fifo_count   frames currently queued
// -----------------------------------------------------------------------------
module frame_serializer_3bit #(
  parameter int                 FRAME_W    = 3,
  parameter int                 DEPTH      = 4,
  parameter logic [FRAME_W-1:0] IDLE_FRAME = 3'b001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FRAME_W-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     serial_out,
  output logic                     frame_start,
  output logic                     idle_out,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [FRAME_W-1:0] shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic               idle_flag;

  logic load;
  logic push;
  logic pop;

  // ">=" rather than "==": an out-of-range bit_cnt is treated as the last
  // bit. The stream then realigns to a frame boundary on the next edge.
  assign load = (bit_cnt >= LAST_BIT);
  // The load decision uses the pre-edge count. A push on the same edge
  // into an empty FIFO therefore waits for the next frame slot.
  assign pop  = load && (count != '0);
  assign push = in_valid && in_ready;

  assign in_ready    = (count < DEPTH_C);
  assign serial_out  = shreg[FRAME_W-1];
  assign frame_start = (bit_cnt == '0);
  assign idle_out    = idle_flag;
  assign fifo_count  = count;

  // NOTE: the storage array has no reset. An entry is only read after it
  // has been written, because count gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments. Every
  // register then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      bit_cnt   <= '0;
      shreg     <= IDLE_FRAME;
      idle_flag <= 1'b1;
    end else begin
      if (load) begin
        bit_cnt <= '0;
        if (pop) begin
          shreg     <= mem[rd_ptr];
          idle_flag <= 1'b0;
          rd_ptr    <= rd_ptr + 1'b1;
        end else begin
          shreg     <= IDLE_FRAME;
          idle_flag <= 1'b1;
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= shreg << 1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serializer_3bit.sv
// -----------------------------------------------------------------------------
// tb_frame_serializer_3bit
//
// Self-checking bench for frame_serializer_3bit.
//
// The reference model tracks four things:
//   - the queue of accepted frames;
//   - the current frame being sent;
//   - whether the current frame is idle fill;
//   - the bit position within the frame, counted from reset.
// Every outputs-valid cycle is compared against this model on the falling
// edge. Directed scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_frame_serializer_3bit;

  localparam int              FRAME_W = 3;
  localparam int              DEPTH   = 4;
  localparam logic [2:0]      IDLE    = 3'b001;

  logic       clk;
  logic       rst;
  logic [2:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       serial_out;
  logic       frame_start;
  logic       idle_out;
  logic [2:0] fifo_count;

  int total;
  int bad;

  frame_serializer_3bit #(
    .FRAME_W   (FRAME_W),
    .DEPTH     (DEPTH),
    .IDLE_FRAME(IDLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .frame_start(frame_start),
    .idle_out   (idle_out),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, updated on each rising edge from pre-edge inputs.
  // ---------------------------------------------------------------------------
  logic [2:0] q[$];
  logic [2:0] cur;
  bit         cur_idle;
  int         phase;
  bit         model_ok;

  initial model_ok = 1'b0;

  always @(posedge clk) begin : model
    int  pre;
    bit  acc;
    if (rst) begin
      q.delete();
      phase    = 0;
      cur      = IDLE;
      cur_idle = 1'b1;
      model_ok = 1'b1;
    end else if (model_ok) begin
      pre = q.size();
      acc = in_valid && (pre < DEPTH);
      if (phase == FRAME_W - 1) begin
        phase = 0;
        if (pre > 0) begin
          cur      = q.pop_front();
          cur_idle = 1'b0;
        end else begin
          cur      = IDLE;
          cur_idle = 1'b1;
        end
      end else begin
        phase++;
      end
      if (acc) q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("serial_out",  32'(serial_out),  32'(cur[FRAME_W-1-phase]));
      check("frame_start", 32'(frame_start), 32'(phase == 0));
      check("idle_out",    32'(idle_out),    32'(cur_idle));
      check("in_ready",    32'(in_ready),    32'(q.size() < DEPTH));
      check("fifo_count",  32'(fifo_count),  32'(q.size()));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (phase != p && n < 10) begin
      tick();
      n++;
    end
    check("wait_phase_timeout", 32'(phase == p), 32'd1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset and idle stream.
    tick();
    tick();
    check("rst_serial", 32'(serial_out),  32'd0);
    check("rst_fstart", 32'(frame_start), 32'd1);
    check("rst_idle",   32'(idle_out),    32'd1);
    check("rst_ready",  32'(in_ready),    32'd1);
    check("rst_count",  32'(fifo_count),  32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("idle_serial", 32'(serial_out),  32'(k % 3 == 2));
      check("idle_fstart", 32'(frame_start), 32'(k % 3 == 0));
      check("idle_flag",   32'(idle_out),    32'd1);
    end

    // Single frame 101, accepted on the edge just before a load edge.
    wait_phase(1);
    in_valid = 1'b1;
    in_data  = 3'b101;
    tick();
    in_valid = 1'b0;
    check("single_count1", 32'(fifo_count), 32'd1);
    tick();
    check("single_count0", 32'(fifo_count), 32'd0);
    check("single_b0",     32'(serial_out), 32'd1);
    check("single_idle",   32'(idle_out),   32'd0);
    tick();
    check("single_b1",     32'(serial_out), 32'd0);
    tick();
    check("single_b2",     32'(serial_out), 32'd1);
    tick();
    check("single_after",  32'(idle_out),   32'd1);

    // Back-to-back frames.
    wait_phase(1);
    begin
      logic [2:0] frames [4];
      frames[0] = 3'b101;
      frames[1] = 3'b110;
      frames[2] = 3'b011;
      frames[3] = 3'b111;
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1;
        in_data  = frames[i];
        tick();
      end
      in_valid = 1'b0;
    end
    repeat (15) tick();

    // Full and backpressure: data 0..5 held valid from just after a load edge.
    wait_phase(0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 3'(i);
      if (i == 5) begin
        check("full_ready", 32'(in_ready),   32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
      end
      tick();
    end
    in_valid = 1'b0;
    check("full_after_pop_ready", 32'(in_ready), 32'd1);
    repeat (18) tick();

    // Push coinciding with the load edge while the FIFO is empty.
    wait_phase(2);
    in_valid = 1'b1;
    in_data  = 3'b110;
    tick();
    in_valid = 1'b0;
    check("pushload_idle",  32'(idle_out),   32'd1);
    check("pushload_count", 32'(fifo_count), 32'd1);
    repeat (3) tick();
    check("pushload_frame_idle", 32'(idle_out),   32'd0);
    check("pushload_frame_b0",   32'(serial_out), 32'd1);
    repeat (6) tick();

    // Reset mid-frame with three frames queued.
    wait_phase(0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 3'b010 + 3'(i);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_count",  32'(fifo_count),  32'd0);
    check("midrst_fstart", 32'(frame_start), 32'd1);
    check("midrst_serial", 32'(serial_out),  32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("midrst_idle", 32'(idle_out), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
